// File: rtl/lab_pkg.sv
// Shared definitions for the button-driven front-end blocks: debounce FSM
// state encoding, sample width and the default debounce interval.
package lab_pkg;

    localparam int SAMPLE_W                = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_e;

endpackage

// File: rtl/sample_capture_if.sv
// Board-control and sample-stash signal bundle for sample_capture.
// The master side drives the raw controls; the slave side produces samples.
interface sample_capture_if;
    import lab_pkg::*;

    logic                btn_sample;
    logic                btn_next;
    logic [SAMPLE_W-1:0] sw;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_in_valid;
    logic                next_sample;

    modport master (
        output btn_sample, btn_next, sw,
        input  sample_in, sample_in_valid, next_sample
    );

    modport slave (
        input  btn_sample, btn_next, sw,
        output sample_in, sample_in_valid, next_sample
    );
endinterface

// File: rtl/debounce_pulse.sv
// Synchronises one raw button and debounces it; press_pulse is high for the
// single cycle in which a press is accepted (WAIT_PRESS -> PRESSED).
module debounce_pulse
    import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          btn_s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // press_pulse is combinational here so the top can register it on the
    // same edge that the FSM enters PRESSED.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = PRESSED;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/sample_capture.sv
// Turns raw switches and sample/next buttons into registered sample_in,
// sample_in_valid and next_sample pulses for the sample stash.
module sample_capture
    import lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    sample_capture_if.slave  bus
);
    logic [1:0]          btn_raw;
    logic [1:0]          press_pulse;
    logic                sample_pulse, next_pulse;
    logic [SAMPLE_W-1:0] sw_meta_q, sw_s_q;
    logic [SAMPLE_W-1:0] sample_in_q, sample_in_d;
    logic                valid_q, valid_d;
    logic                next_q, next_d;
    logic                pend_q, pend_d;

    assign btn_raw      = {bus.btn_next, bus.btn_sample};
    assign sample_pulse = press_pulse[0];
    assign next_pulse   = press_pulse[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            debounce_pulse #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset      (reset),
                .btn_raw    (btn_raw[gi]),
                .press_pulse(press_pulse[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            sample_in_q <= '0;
            valid_q     <= 1'b0;
            next_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            sw_meta_q   <= bus.sw;
            sw_s_q      <= sw_meta_q;
            sample_in_q <= sample_in_d;
            valid_q     <= valid_d;
            next_q      <= next_d;
            pend_q      <= pend_d;
        end
    end

    // A capture always owns its cycle; a coincident next press is parked in
    // pend_q and released on the following cycle.
    always_comb begin
        sample_in_d = sample_in_q;
        valid_d     = 1'b0;
        next_d      = 1'b0;
        pend_d      = pend_q;
        if (sample_pulse) begin
            sample_in_d = sw_s_q;
            valid_d     = 1'b1;
            if (next_pulse) begin
                pend_d = 1'b1;
            end
        end else if (next_pulse || pend_q) begin
            next_d = 1'b1;
            pend_d = 1'b0;
        end
    end

    assign bus.sample_in       = sample_in_q;
    assign bus.sample_in_valid = valid_q;
    assign bus.next_sample     = next_q;
endmodule

// File: doc/sample_capture.md
# sample_capture

Front-end stage that produces the `sample_in` / `sample_in_valid` / `next_sample` inputs of the sample stash from raw board controls. It synchronises an 8-bit switch bank and two push-buttons, one for "sample" and one for "next", to `clk`. It debounces each button and emits exactly one single-cycle pulse per debounced press. On each "sample" press it latches the switch value as the new sample.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000 (1 ms at 100 MHz): consecutive stable cycles required to accept a press or a release. Legal range is 2 or more.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `btn_sample`  in  1  raw, asynchronous, bouncy "sample" button. Active high.
- `btn_next`  in  1  raw, asynchronous, bouncy "next" button. Active high.
- `sw`  in  8  raw, asynchronous switch bank.
- `sample_in`  out  8  last captured switch value. Registered; held between captures.
- `sample_in_valid`  out  1  one-cycle pulse marking a new `sample_in`.
- `next_sample`  out  1  one-cycle pulse per debounced "next" press.

## Operation
- **Synchronisers.** `btn_sample`, `btn_next` and `sw[7:0]` each pass through a 2-flop synchroniser. All logic after that uses only the second-stage outputs (`*_s`).
- **Debounce FSM.** There is one FSM per button, each with its own counter of width `$clog2(DEBOUNCE_CYCLES)`. States and transitions:
  - IDLE: if `s=1`, go to WAIT_PRESS with `cnt=0`.
  - WAIT_PRESS:
    - if `s=0`, go to IDLE;
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to PRESSED and emit the pulse;
    - else `cnt++`.
  - PRESSED: if `s=0`, go to WAIT_RELEASE with `cnt=0`.
  - WAIT_RELEASE:
    - if `s=1`, go to PRESSED, with no pulse;
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to IDLE;
    - else `cnt++`.
- **Pulse rule.** A pulse is emitted only on the WAIT_PRESS→PRESSED transition, so one debounced press gives exactly one pulse. Holding the button longer gives no further pulses.
- **Sample capture.** On a sample-button pulse, `sample_in <= sw_s` and `sample_in_valid <= 1`, both updated on the same edge.
- **Simultaneous events.** If the sample and next pulses occur on the same edge:
  - `sample_in_valid` wins;
  - the next event is stored in a 1-bit pending flag;
  - `next_sample` is asserted on the following cycle.
- **No overlap.** `next_sample` and `sample_in_valid` are never high in the same cycle.
- **Pending flag depth.** The flag never has to hold two events, because two pulses of one button are separated by at least `2*DEBOUNCE_CYCLES` cycles.
- **Reset (`reset==0` at an edge).** Everything returns to its initial value:
  - synchroniser flops → 0;
  - FSMs → IDLE;
  - counters → 0;
  - pending flag → 0;
  - `sample_in` → 8'h00;
  - `sample_in_valid` → 0;
  - `next_sample` → 0.
- **Reset mid-operation.** Reset aborts any debounce in progress and cancels any pending pulse. A button held while reset deasserts is treated as a new press: it yields one pulse after the full latency.

## Timing
- Edge k is the first rising edge at which the raw button is sampled high. If the input is then stable:
  - the debounce FSM is in WAIT_PRESS after edge k+2;
  - the pulse is high after edge k+2+DEBOUNCE_CYCLES, for exactly one cycle.
- A deferred `next_sample` appears one cycle later, after edge k+3+DEBOUNCE_CYCLES.
- **Captured switch value.** `sample_in` takes the value of `sw` that was stable at the pin from edge k+DEBOUNCE_CYCLES onward, i.e. 2 edges of synchroniser delay.
- **Output behaviour.** All outputs are registered, with no combinational path from any input. `sample_in` changes only at a capture or at reset.

## Structure
- **Sub-module `debounce_pulse`**, instantiated twice. It contains the 2-flop synchroniser, the 4-state FSM and the counter.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `btn_raw` (in), `press_pulse` (out).
- **Top level.** The `sw` synchronisers, the capture register and the pending/priority logic live in the top level.
- **Shared package `lab_pkg`.** It holds:
  - the FSM state encodings IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_RELEASE=2'd3;
  - the constant `SAMPLE_W=8`;
  - the default debounce constant, for reuse by other button-driven blocks.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset:** hold `reset=0` for 3 cycles with both buttons high and `sw=8'hFF` → all outputs 0 throughout. After release, one `sample_in_valid` pulse after edge k+6 with `sample_in=8'hFF`.
- **Clean press:** `sw=8'hA5`, raise `btn_sample` at edge k and hold 20 cycles → `sample_in_valid` high only in the cycle after edge k+6, with `sample_in=8'hA5` held afterwards. No second pulse.
- **Press bounce:** `btn_sample` toggles 1,0,1,0 at 2-cycle intervals, then stays high from edge m → exactly one pulse, after edge m+6.
- **Release bounce:** while the FSM is PRESSED, drop the button for 2 cycles then raise it → no pulse. After a clean release of 6 or more cycles followed by a re-press with `sw=8'h3C` → second pulse with `sample_in=8'h3C`.
- **Simultaneous presses:** both buttons rise at edge k with `sw=8'h5A` → `sample_in_valid` after edge k+6 and `next_sample` after edge k+7, never in the same cycle.
- **Reset mid-debounce:** press at edge k, assert reset at edge k+4 for 1 cycle, release the button before reset ends → no pulse at all, and `sample_in=8'h00`.
